// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target front end: FSM encoding, 10-bit prefix, bus ack levels.
package i2c_pkg;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StAddr1   = 4'd1;
  localparam logic [3:0] StAddr2   = 4'd2;
  localparam logic [3:0] StAckAddr = 4'd3;
  localparam logic [3:0] StWrData  = 4'd4;
  localparam logic [3:0] StAckWr   = 4'd5;
  localparam logic [3:0] StRdData  = 4'd6;
  localparam logic [3:0] StRdAck   = 4'd7;
  localparam logic [3:0] StIgnore  = 4'd8;

  localparam logic [4:0] START_PREFIX_10B = 5'b11110;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw scl/sda and derives scl edges plus START/STOP bus conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_cond,
  output logic stop_cond
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  // Flops reset to the idle-bus level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda        = sda_s;
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_cond = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_cond  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_frontend.sv
// I2C target front end: address match over NUM_CH channels, write byte strobes, read byte fetch.
module i2c_target_frontend
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR10      = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CH_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  input  logic [NUM_CH*10-1:0]   own_addr,
  input  logic [NUM_CH-1:0]      ch_en,
  output logic                   busy,
  output logic                   sel,
  output logic [CH_W-1:0]        sel_ch,
  output logic                   rw,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_req,
  output logic                   start_det,
  output logic                   stop_det,
  output logic                   nack_det
);

  logic sda_s, scl_rise, scl_fall, start_cond, stop_cond;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda        (sda_s),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_cond (start_cond),
    .stop_cond  (stop_cond)
  );

  logic [3:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [6:0]      shift_q, shift_d;
  logic [6:0]      tx_shift_q, tx_shift_d;
  logic            tx_ld_q;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            sel_q, sel_d;
  logic [CH_W-1:0] sel_ch_q, sel_ch_d;
  logic            rw_q, rw_d;
  logic [1:0]      hi_q, hi_d;
  logic            matched_q, matched_d;
  logic            addr2_pend_q, addr2_pend_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_req_q, tx_req_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            nack_q, nack_d;

  // The byte as it stands including the bit being sampled this clk.
  logic [7:0]        byte_in;
  logic [NUM_CH-1:0] hit7, hit_hi, hit10, hit_vec;
  logic [CH_W-1:0]   hit_idx;
  logic              hit_sr;

  assign byte_in = {shift_q, sda_s};

  always_comb begin
    hit7    = '0;
    hit_hi  = '0;
    hit10   = '0;
    hit_sr  = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit7[k]   = ch_en[k] && (own_addr[10*k +: 7] == byte_in[7:1]);
      hit_hi[k] = ch_en[k] && (own_addr[10*k+8 +: 2] == byte_in[2:1]);
      hit10[k]  = ch_en[k] && (own_addr[10*k +: 10] == {hi_q, byte_in});
    end
    hit_vec = (state_q == StAddr2) ? hit10 : hit7;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (hit_vec[k]) hit_idx = CH_W'(k);
    end
    // 10-bit read after Sr reuses the channel fully matched earlier in this busy period.
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch_q == CH_W'(k) && hit_hi[k]) hit_sr = matched_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    sel_d        = sel_q;
    sel_ch_d     = sel_ch_q;
    rw_d         = rw_q;
    hi_d         = hi_q;
    matched_d    = matched_q;
    addr2_pend_d = addr2_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    nack_d       = 1'b0;

    if (stop_cond) begin
      state_d      = StIdle;
      busy_d       = 1'b0;
      sel_d        = 1'b0;
      oe_d         = 1'b0;
      stop_d       = 1'b1;
      matched_d    = 1'b0;
      addr2_pend_d = 1'b0;
      cnt_d        = '0;
    end else if (start_cond) begin
      state_d      = StAddr1;
      busy_d       = 1'b1;
      sel_d        = 1'b0;
      oe_d         = 1'b0;
      start_d      = 1'b1;
      addr2_pend_d = 1'b0;
      cnt_d        = '0;
    end else begin
      if (tx_ld_q && state_q == StRdData) begin
        tx_shift_d = tx_data[6:0];
        oe_d       = ~tx_data[7];
      end
      case (state_q)
        StAddr1, StAddr2: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == StAddr2) begin
                if (|hit10) begin
                  sel_d     = 1'b1;
                  sel_ch_d  = hit_idx;
                  rw_d      = 1'b0;
                  matched_d = 1'b1;
                end else begin
                  state_d = StIgnore;
                end
              end else if (ADDR10 == 0) begin
                if (|hit7) begin
                  sel_d    = 1'b1;
                  sel_ch_d = hit_idx;
                  rw_d     = byte_in[0];
                end else begin
                  state_d = StIgnore;
                end
              end else if (byte_in[7:3] != START_PREFIX_10B) begin
                state_d = StIgnore;
              end else if (!byte_in[0]) begin
                if (|hit_hi) begin
                  hi_d         = byte_in[2:1];
                  addr2_pend_d = 1'b1;
                end else begin
                  state_d = StIgnore;
                end
              end else if (hit_sr) begin
                sel_d = 1'b1;
                rw_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d    = ~ACK;
            state_d = StAckAddr;
            cnt_d   = '0;
          end
        end
        StAckAddr: begin
          if (scl_fall) begin
            oe_d  = 1'b0;
            cnt_d = '0;
            if (addr2_pend_q) begin
              state_d      = StAddr2;
              addr2_pend_d = 1'b0;
            end else if (rw_q) begin
              state_d  = StRdData;
              tx_req_d = 1'b1;
            end else begin
              state_d = StWrData;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d    = ~ACK;
            state_d = StAckWr;
            cnt_d   = '0;
          end
        end
        StAckWr: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = StWrData;
          end
        end
        StRdData: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = StRdAck;
              cnt_d   = '0;
            end else begin
              oe_d       = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              nack_d  = 1'b1;
              state_d = StIgnore;
            end
          end else if (scl_fall) begin
            state_d  = StRdData;
            tx_req_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      tx_shift_q   <= '0;
      tx_ld_q      <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= 1'b0;
      sel_ch_q     <= '0;
      rw_q         <= 1'b0;
      hi_q         <= '0;
      matched_q    <= 1'b0;
      addr2_pend_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_shift_q   <= tx_shift_d;
      tx_ld_q      <= tx_req_q;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
      sel_ch_q     <= sel_ch_d;
      rw_q         <= rw_d;
      hi_q         <= hi_d;
      matched_q    <= matched_d;
      addr2_pend_q <= addr2_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      nack_q       <= nack_d;
    end
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign sel       = sel_q;
  assign sel_ch    = sel_ch_q;
  assign rw        = rw_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign nack_det  = nack_q;

endmodule

// File: tb/tb_i2c_target_frontend.sv
// Bench: a 7-bit and a 10-bit target share one wired-AND bus driven by a behavioural master.
`timescale 1ns/1ps
module tb_i2c_target_frontend;
  import i2c_pkg::*;

  localparam int Q = 40;  // quarter scl period, 4 clk

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic scl_m, sda_m, bus_sda;
  logic oe7, oe10;
  assign bus_sda = sda_m & ~oe7 & ~oe10;

  logic [19:0] own7, own10;
  logic [1:0]  ch_en7, ch_en10;
  logic        busy7, sel7, rw7, rx_valid7, tx_req7, start7, stop7, nack7;
  logic        busy10, sel10, rw10, rx_valid10, tx_req10, start10, stop10, nack10;
  logic [2:0]  sel_ch7, sel_ch10;
  logic [7:0]  rx_data7, rx_data10, tx_data7, tx_data10;

  i2c_target_frontend #(.NUM_CH(2), .ADDR10(0), .SYNC_STAGES(2), .CH_W(3)) dut7 (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(bus_sda), .sda_oe(oe7),
    .own_addr(own7), .ch_en(ch_en7), .busy(busy7), .sel(sel7), .sel_ch(sel_ch7), .rw(rw7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .tx_data(tx_data7), .tx_req(tx_req7),
    .start_det(start7), .stop_det(stop7), .nack_det(nack7)
  );

  i2c_target_frontend #(.NUM_CH(2), .ADDR10(1), .SYNC_STAGES(2), .CH_W(3)) dut10 (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(bus_sda), .sda_oe(oe10),
    .own_addr(own10), .ch_en(ch_en10), .busy(busy10), .sel(sel10), .sel_ch(sel_ch10), .rw(rw10),
    .rx_data(rx_data10), .rx_valid(rx_valid10), .tx_data(tx_data10), .tx_req(tx_req10),
    .start_det(start10), .stop_det(stop10), .nack_det(nack10)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: expected write bytes, bytes to hand out on tx_req, expected read bytes.
  logic [7:0] rx_exp7[$], rx_exp10[$], tx_src7[$], tx_src10[$], rd_exp7[$], rd_exp10[$];
  int n_rx7 = 0, n_rx10 = 0, n_txreq7 = 0, n_txreq10 = 0;
  int n_start7 = 0, n_start10 = 0, n_stop7 = 0, n_stop10 = 0, n_nack7 = 0, n_nack10 = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rx_valid7) begin
      n_rx7++;
      if (rx_exp7.size() != 0) e = 32'(rx_exp7.pop_front()); else e = 32'h100;
      check_eq("rx7_byte", 32'(rx_data7), e);
    end
    if (rx_valid10) begin
      n_rx10++;
      if (rx_exp10.size() != 0) e = 32'(rx_exp10.pop_front()); else e = 32'h100;
      check_eq("rx10_byte", 32'(rx_data10), e);
    end
    if (tx_req7) begin
      n_txreq7++;
      if (tx_src7.size() != 0) begin
        tx_data7 = tx_src7.pop_front();
        rd_exp7.push_back(tx_data7);
      end
    end
    if (tx_req10) begin
      n_txreq10++;
      if (tx_src10.size() != 0) begin
        tx_data10 = tx_src10.pop_front();
        rd_exp10.push_back(tx_data10);
      end
    end
    if (start7)  n_start7++;
    if (start10) n_start10++;
    if (stop7)   n_stop7++;
    if (stop10)  n_stop10++;
    if (nack7)   n_nack7++;
    if (nack10)  n_nack10++;
  end

  task automatic bus_start();
    sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = bus_sda; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(input string tag, input bit is10, input logic mack);
    logic [7:0]  d;
    logic [31:0] e;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; d = {d[6:0], bus_sda}; #Q; scl_m = 1'b0; #Q;
    end
    if (is10 && rd_exp10.size() != 0)      e = 32'(rd_exp10.pop_front());
    else if (!is10 && rd_exp7.size() != 0) e = 32'(rd_exp7.pop_front());
    else                                   e = 32'h100;
    check_eq(tag, 32'(d), e);
    write_bit(mack);
  endtask

  logic ack;
  int   s0, s1, s2;

  initial begin
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tx_data7 = '0; tx_data10 = '0;
    own7  = {10'h050, 10'h030};
    own10 = {10'h155, 10'h2B7};
    ch_en7 = 2'b11; ch_en10 = 2'b11;
    repeat (3) @(negedge clk);
    check_eq("reset7", {12'b0, oe7, busy7, sel7, sel_ch7, rw7, rx_data7, rx_valid7, tx_req7,
                        start7, stop7, nack7}, 32'h0);
    check_eq("reset10", {12'b0, oe10, busy10, sel10, sel_ch10, rw10, rx_data10, rx_valid10,
                         tx_req10, start10, stop10, nack10}, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 7-bit write to ch1 (7'h50)
    s0 = n_stop7; s1 = n_rx7;
    bus_start();
    write_byte(8'hA0, ack); check_eq("w7_addr_ack", ack, ACK);
    check_eq("w7_sel", sel7, 1'b1);
    check_eq("w7_sel_ch", sel_ch7, 3'd1);
    check_eq("w7_rw", rw7, 1'b0);
    check_eq("w7_busy", busy7, 1'b1);
    rx_exp7.push_back(8'h3C); write_byte(8'h3C, ack); check_eq("w7_d0_ack", ack, ACK);
    rx_exp7.push_back(8'hC3); write_byte(8'hC3, ack); check_eq("w7_d1_ack", ack, ACK);
    bus_stop();
    check_eq("w7_stop_cnt", n_stop7 - s0, 1);
    check_eq("w7_rx_cnt", n_rx7 - s1, 2);
    check_eq("w7_busy_after", busy7, 1'b0);
    check_eq("w7_sel_after", sel7, 1'b0);

    // 7-bit read: ACK byte 1, NACK byte 2
    tx_src7.push_back(8'hA5); tx_src7.push_back(8'h5A);
    s0 = n_txreq7; s1 = n_nack7;
    bus_start();
    write_byte(8'hA1, ack); check_eq("r7_addr_ack", ack, ACK);
    check_eq("r7_rw", rw7, 1'b1);
    read_byte("r7_byte0", 1'b0, ACK);
    read_byte("r7_byte1", 1'b0, NACK);
    check_eq("r7_txreq_cnt", n_txreq7 - s0, 2);
    check_eq("r7_nack_cnt", n_nack7 - s1, 1);
    check_eq("r7_oe_released", oe7, 1'b0);
    bus_stop();

    // Non-matching address, then matching address on a disabled channel
    s0 = n_rx7;
    bus_start();
    write_byte(8'hA2, ack); check_eq("nm_addr_nack", ack, NACK);
    check_eq("nm_sel", sel7, 1'b0);
    write_byte(8'h55, ack); check_eq("nm_data_nack", ack, NACK);
    bus_stop();
    ch_en7 = 2'b01;
    bus_start();
    write_byte(8'hA0, ack); check_eq("dis_addr_nack", ack, NACK);
    check_eq("dis_sel", sel7, 1'b0);
    write_byte(8'h66, ack); check_eq("dis_data_nack", ack, NACK);
    bus_stop();
    ch_en7 = 2'b11;
    check_eq("nm_rx_cnt", n_rx7 - s0, 0);

    // 10-bit write F4 B7 11, then Sr F5 read
    s0 = n_start10; s1 = n_rx10; s2 = n_txreq10;
    bus_start();
    write_byte(8'hF4, ack); check_eq("a10_hdr_ack", ack, ACK);
    write_byte(8'hB7, ack); check_eq("a10_lo_ack", ack, ACK);
    check_eq("a10_sel", sel10, 1'b1);
    check_eq("a10_sel_ch", sel_ch10, 3'd0);
    check_eq("a10_rw_w", rw10, 1'b0);
    rx_exp10.push_back(8'h11); write_byte(8'h11, ack); check_eq("a10_d_ack", ack, ACK);
    tx_src10.push_back(8'h96);
    bus_rstart();
    write_byte(8'hF5, ack); check_eq("a10_sr_ack", ack, ACK);
    check_eq("a10_rw_r", rw10, 1'b1);
    check_eq("a10_sel_r", sel10, 1'b1);
    check_eq("a10_sel_ch_r", sel_ch10, 3'd0);
    check_eq("a10_start_cnt", n_start10 - s0, 2);
    read_byte("a10_rd", 1'b1, NACK);
    bus_stop();
    check_eq("a10_rx_cnt", n_rx10 - s1, 1);
    check_eq("a10_txreq_cnt", n_txreq10 - s2, 1);
    check_eq("a10_busy_after", busy10, 1'b0);

    // STOP after 4 data bits
    s0 = n_rx7;
    bus_start();
    write_byte(8'hA0, ack); check_eq("ms_addr_ack", ack, ACK);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    check_eq("ms_busy", busy7, 1'b0);
    check_eq("ms_sel", sel7, 1'b0);
    check_eq("ms_oe", oe7, 1'b0);
    check_eq("ms_rx_cnt", n_rx7 - s0, 0);

    // Async reset while ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hA0 >> i));
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    check_eq("rst_ack_driven", oe7, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("rst_async_oe", oe7, 1'b0);
    check_eq("rst_async_busy", busy7, 1'b0);
    #(Q-1); scl_m = 1'b0; #Q; rst = 1'b1; #Q;
    bus_stop();

    // Both channels at 7'h20: lowest index wins
    own7 = {10'h020, 10'h020};
    bus_start();
    write_byte(8'h40, ack); check_eq("dup_ack", ack, ACK);
    check_eq("dup_sel", sel7, 1'b1);
    check_eq("dup_sel_ch", sel_ch7, 3'd0);
    bus_stop();
    own7 = {10'h050, 10'h030};

    repeat (8) @(negedge clk);
    check_eq("end_rx7_empty", rx_exp7.size(), 0);
    check_eq("end_rx10_empty", rx_exp10.size(), 0);
    check_eq("end_rd7_empty", rd_exp7.size(), 0);
    check_eq("end_rd10_empty", rd_exp10.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_frontend.md
Name: i2c_target_frontend

Overview:
- Synthesizable I2C target (slave) front end that replaces the bench-side frame checker with real RTL.
- Detects START, repeated START and STOP, and shifts in 7- or 10-bit addresses.
- Matches the address against NUM_CH programmable channel addresses and drives ACK.
- Moves data bytes both ways: writes as a received-byte strobe, reads from a tx byte interface. Sits between the top-level open-drain sda/scl pins and the register/control logic.

Parameters:
- NUM_CH, 2, number of independent target addresses matched (1..8)
- ADDR10, 0, 0 = 7-bit addressing, 1 = 10-bit addressing (11110 prefix scheme)
- SYNC_STAGES, 2, synchronizer depth on scl/sda inputs (min 2)
- CH_W, 3, width of match index (clog2 of NUM_CH, min 1)

Ports:
- clk  in  1  system clock, at least 8x scl rate
- rst  in  1  asynchronous, active-low reset
- scl_in  in  1  raw scl pin level
- sda_in  in  1  raw sda pin level
- sda_oe  out  1  1 = pull sda low (top drives pin to 0 when set, Z otherwise)
- own_addr  in  NUM_CH*10  channel addresses, channel k at bits [10k+9:10k]; 7-bit mode uses [6:0]
- ch_en  in  NUM_CH  per-channel match enable
- busy  out  1  high from START to STOP
- sel  out  1  high while an addressed transaction is in progress
- sel_ch  out  CH_W  index of matched channel (lowest index wins)
- rw  out  1  latched R/W bit of the current transaction (1 = read)
- rx_data  out  8  last received write byte
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  8  byte to return on read
- tx_req  out  1  one-cycle strobe requesting tx_data; sampled 2 clk later
- start_det  out  1  one-cycle strobe on START or repeated START
- stop_det  out  1  one-cycle strobe on STOP
- nack_det  out  1  one-cycle strobe when the master NACKs a read byte

Behaviour:
- Reset (rst=0, async): all outputs 0, sda_oe=0, state IDLE, shift register and bit counter 0.
- Input sampling: scl_in and sda_in pass through SYNC_STAGES flops. Edges are detected against a one-flop history. All decisions use synchronized values; latency from pin to decision is SYNC_STAGES+1 clk.
- Bus conditions:
  - START = sda falls while scl high.
  - STOP = sda rises while scl high.
  - Both are valid in any state.
  - START resets the bit counter and enters ADDR1.
  - STOP returns to IDLE and clears busy, sel and sda_oe.
- Sampling and driving:
  - Data bits are sampled on the scl rising edge, MSB first.
  - sda_oe changes only on the scl falling edge.
- States: IDLE, ADDR1, ADDR2, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE.
- ADDR1 (8 bits):
  - 7-bit mode: bits[7:1] are the address and bit0 is rw. Compare against own_addr[6:0] of each enabled channel.
  - 10-bit mode: bits[7:3] must equal 11110; bits[2:1] are a9:a8. Any other prefix -> IGNORE.
  - 10-bit write: ACK, then go to ADDR2 for a7:a0 and a full 10-bit compare.
  - 10-bit repeated START with prefix+rw=1 after a prior full match in the same busy period: ACK and go to RD_DATA without ADDR2.
- Match handling:
  - On match: latch sel_ch and rw, assert sel, and drive ACK for exactly the 9th scl cycle (sda_oe=1 from the falling edge after bit 8 to the next falling edge).
  - On no match: IGNORE with no ACK, held until START or STOP.
- WR_DATA:
  - After 8 bits, set rx_data and pulse rx_valid on the 8th-bit rising-edge sample.
  - ACK every byte (ACK_WR), then return to WR_DATA.
  - Byte count is unbounded.
- RD_DATA:
  - tx_req pulses on entry to each byte, at the scl falling edge of the ACK cycle.
  - tx_data is loaded 2 clk later.
  - Each bit is driven as sda_oe = ~bit on scl falling edges.
- RD_ACK:
  - Release sda and sample the master bit on the 9th rising edge.
  - 0 -> next byte.
  - 1 -> nack_det pulse, IGNORE until STOP or START.
- Simultaneous events: START/STOP take priority over any bit sample in the same clk. A START during an ACK or read bit releases sda_oe in that same clk.
- Multiple channel matches: lowest index wins.
- ch_en changes take effect at the next address phase only.
- Mid-operation async reset releases sda immediately.
- A START while busy is a repeated START: start_det pulses and busy stays high.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants;
  - START_PREFIX_10B = 5'b11110;
  - ACK = 1'b0, NACK = 1'b1.
- Natural sub-module: i2c_line_sync. It contains the SYNC_STAGES synchronizer and edge/condition detector, and outputs scl_rise, scl_fall, start_cond and stop_cond.

Test Plan:
- 7-bit write, own_addr ch1 = 7'h50, ch_en = 2'b11: START, byte A0, bytes 3C and C3, STOP -> ACK on all 3 bytes, sel_ch=1, rw=0, rx_valid twice (3C then C3), stop_det once, busy low after.
- 7-bit read to 7'h50 with tx_data = 8'hA5 then 8'h5A: master ACKs byte 1 and NACKs byte 2 -> sda shows A5 then 5A, tx_req twice, nack_det once, sda_oe=0 after the 9th cycle.
- Non-matching address 7'h51, or matching address with ch_en=0: START, byte A2 -> no ACK (sda_oe stays 0), sel=0, no rx_valid on following bytes.
- ADDR10=1, own_addr ch0 = 10'h2B7: write F4 B7 11, then repeated START F5 read -> ACK on F4, B7 and 11; rx 11; after Sr, read proceeds with sel_ch=0, rw=1, and start_det pulsing twice.
- STOP injected mid-byte during WR_DATA after 4 bits -> state IDLE, no rx_valid, busy=0. rst pulled low while sda_oe=1 during ACK -> sda_oe=0 asynchronously.
- Both channels set to 7'h20 -> match reports sel_ch=0.
